cw_capture_ctrl: RTL and testbench

Capture sequencer for the ChipWatcher trace buffer. It drives the trace-RAM write port (`wt_ce`, `wt_en`, `wt_addr`) from the trigger domain. It implements arm, pre-trigger fill, trigger wait with circular wrap, post-trigger count and done. It sits between the trigger comparator and the trace RAM inside `cwc_top`, and its status is sampled by the JTAG status register.

---
 rtl/cw_capture_ctrl.sv | 111 +++++++++++
 tb/tb_cw_capture_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cw_capture_ctrl.sv
// cw_capture_ctrl: trace-RAM capture sequencer (arm, pre-fill, circular trigger wait, post count, done).
// Define CW_CAPTURE_QUAL_EN to honour sample_qual as a per-sample storage qualifier.
module cw_capture_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        trig_clk,
  input  logic        trig_rstn,
  input  logic        arm,
  input  logic        abort,
  input  logic [15:0] pre_len,
  input  logic        trig_hit,
  input  logic        sample_qual,
  output logic        wt_ce,
  output logic        wt_en,
  output logic [15:0] wt_addr,
  output logic [15:0] trig_addr,
  output logic [15:0] start_addr,
  output logic [1:0]  state,
  output logic        triggered,
  output logic        done,
  output logic        wrapped
);
  localparam int AW = DEPTH_LOG2;
  localparam logic [AW-1:0] AMAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t fsm_q, fsm_d, ph;
  logic [AW-1:0] ptr_q, ptr_d, cnt_q, cnt_d, pre_q, pre_d, addr_q, addr_d;
  logic [AW-1:0] taddr_q, taddr_d, saddr_q, saddr_d;
  logic [AW-1:0] pre_new, pe, ptr, cnt, cnt_n;
  logic [1:0] st_q, st_d;
  logic ce_q, ce_d, en_q, en_d, trg_q, trg_d, done_q, done_d, wrap_q, wrap_d;
  logic qual, arm_acc, abt, act, go, hit, last;
`ifdef CW_CAPTURE_QUAL_EN
  assign qual = sample_qual;
`else
  logic unused_qual;
  assign qual = 1'b1;
  assign unused_qual = sample_qual;
`endif
  // ph is the phase that owns the sample presented this cycle; an accepted
  // arm makes that very sample the first write of the new capture.
  always_comb begin
    arm_acc = arm & (fsm_q == S_IDLE || fsm_q == S_DONE);
    abt = abort & (fsm_q inside {S_PRE, S_WAIT, S_POST});
    pre_new = (pre_len > 16'(AMAX)) ? AMAX : pre_len[AW-1:0];
    pe = arm_acc ? pre_new : pre_q;
    ph = arm_acc ? ((pre_new == '0) ? S_WAIT : S_PRE) : fsm_q;
    ptr = arm_acc ? '0 : ptr_q;
    cnt = arm_acc ? '0 : cnt_q;
    cnt_n = cnt + 1'b1;
    act = (ph inside {S_PRE, S_WAIT, S_POST}) & ~abt;
    go = act & qual;
    hit = go & (ph == S_WAIT) & trig_hit;
    last = (ph == S_PRE) ? (cnt_n == pe) : (cnt_n == AMAX - pe);
    fsm_d = abt ? S_IDLE
          : hit ? ((pe == AMAX) ? S_DONE : S_POST)
          : (go && ph != S_WAIT && last) ? ((ph == S_PRE) ? S_WAIT : S_DONE)
          : ph;
    cnt_d = (go && ph != S_WAIT) ? (last ? '0 : cnt_n) : (hit ? '0 : cnt);
    ptr_d = go ? ptr + 1'b1 : ptr;
    addr_d = go ? ptr : (arm_acc ? '0 : addr_q);
    pre_d = pe;
    en_d = go;
    ce_d = act;
    st_d = act ? ph[1:0] : 2'd0;
    done_d = (fsm_q == S_DONE) & ~arm_acc;
    trg_d = hit | (trg_q & ~arm_acc);
    taddr_d = hit ? ptr : (arm_acc ? '0 : taddr_q);
    saddr_d = hit ? ptr - pe : (arm_acc ? '0 : saddr_q);
    wrap_d = (go & ~arm_acc & (addr_q == AMAX)) | (wrap_q & ~arm_acc);
  end
  always_ff @(posedge trig_clk or negedge trig_rstn)
    if (!trig_rstn) begin
      fsm_q <= S_IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
      addr_q <= '0;
      taddr_q <= '0;
      saddr_q <= '0;
      st_q <= '0;
      ce_q <= 1'b0;
      en_q <= 1'b0;
      trg_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      addr_q <= addr_d;
      taddr_q <= taddr_d;
      saddr_q <= saddr_d;
      st_q <= st_d;
      ce_q <= ce_d;
      en_q <= en_d;
      trg_q <= trg_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  assign wt_ce = ce_q;
  assign wt_en = en_q;
  assign wt_addr = 16'(addr_q);
  assign trig_addr = 16'(taddr_q);
  assign start_addr = 16'(saddr_q);
  assign state = st_q;
  assign triggered = trg_q;
  assign done = done_q;
  assign wrapped = wrap_q;
endmodule

// File: tb/tb_cw_capture_ctrl.sv
// tb_cw_capture_ctrl: directed capture scenarios at DEPTH=16 with hand-computed expectations.
module tb_cw_capture_ctrl;
  logic clk = 1'b0, rstn = 1'b0, arm = 1'b0, abort = 1'b0, trig_hit = 1'b0, sample_qual = 1'b1;
  logic [15:0] pre_len = '0;
  logic wt_ce, wt_en, triggered, done, wrapped;
  logic [15:0] wt_addr, trig_addr, start_addr;
  logic [1:0] state;
  logic [54:0] all_o;
  int n_cmp = 0, n_bad = 0;
  int wa[$], ws[$];
  int t_trig, t_done;
  logic f_trg, f_wrap, f_done;

  cw_capture_ctrl #(.DEPTH_LOG2(4)) dut (
    .trig_clk(clk), .trig_rstn(rstn), .arm(arm), .abort(abort), .pre_len(pre_len),
    .trig_hit(trig_hit), .sample_qual(sample_qual), .wt_ce(wt_ce), .wt_en(wt_en),
    .wt_addr(wt_addr), .trig_addr(trig_addr), .start_addr(start_addr), .state(state),
    .triggered(triggered), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;
  assign all_o = {wt_ce, wt_en, wt_addr, trig_addr, start_addr, state, triggered, done, wrapped};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nst(input int s);
    int n = 0;
    foreach (ws[i]) if (ws[i] == s) n++;
    return n;
  endfunction

  // Sample j is driven on the negedge before the edge that captures it; outputs
  // are observed on the following negedge. trig_hit is high from sample trig_from on.
  task automatic run(input logic [15:0] p, input int trig_from);
    wa.delete();
    ws.delete();
    t_trig = -1;
    t_done = -1;
    @(negedge clk);
    arm = 1'b1;
    pre_len = p;
    trig_hit = (trig_from <= 1);
    for (int j = 2; j <= 60 && t_done < 0; j++) begin
      @(negedge clk);
      arm = 1'b0;
      if (j == 2) begin
        f_trg = triggered;
        f_wrap = wrapped;
        f_done = done;
      end
      if (wt_en) begin
        wa.push_back(int'(wt_addr));
        ws.push_back(int'(state));
      end
      if (triggered && t_trig < 0) t_trig = j;
      if (done) t_done = j;
      trig_hit = (j >= trig_from);
    end
    trig_hit = 1'b0;
    if (t_done < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_o, 0);
    rstn = 1'b1;
    // basic: pre 4, trigger on the 10th sample
    run(16'd4, 10);
    chk("bas_pre_writes", nst(1), 4);
    chk("bas_pre_addr3", wa[3], 3);
    chk("bas_trig_addr", trig_addr, 9);
    chk("bas_post_writes", nst(3), 11);
    chk("bas_total_writes", wa.size(), 21);
    chk("bas_last_addr", wa[$], 4);
    chk("bas_wrapped", wrapped, 1);
    chk("bas_start_addr", start_addr, 5);
    chk("bas_done_latency", t_done - t_trig, 12);
    chk("bas_done_idle", {wt_ce, wt_en, state, done}, 5'b00001);
    chk("bas_hold_addr", wt_addr, 4);
    // early trigger, armed from DONE
    run(16'd4, 1);
    chk("rearm_flags_clear", {f_trg, f_wrap, f_done}, 0);
    chk("rearm_first_addr", wa[0], 0);
    chk("early_trig_addr", trig_addr, 4);
    chk("early_start_addr", start_addr, 0);
    chk("early_total", wa.size(), 16);
    chk("early_no_wrap", wrapped, 0);
    // clamp: pre 100 -> 15, trigger on first WAIT sample
    run(16'd100, 16);
    chk("clamp_pre_writes", nst(1), 15);
    chk("clamp_trig_addr", trig_addr, 15);
    chk("clamp_post_writes", nst(3), 0);
    chk("clamp_done_latency", t_done - t_trig, 1);
    chk("clamp_start_addr", start_addr, 0);
    // zero pre window
    run(16'd0, 3);
    chk("zero_first_state", ws[0], 2);
    chk("zero_pre_writes", nst(1), 0);
    chk("zero_trig_addr", trig_addr, 2);
    chk("zero_post_writes", nst(3), 15);
    chk("zero_total", wa.size(), 18);
    chk("zero_last_addr", wt_addr, 1);
    chk("zero_start_addr", start_addr, 2);
    chk("zero_wrapped", wrapped, 1);
    // asynchronous reset in POST
    @(negedge clk);
    arm = 1'b1;
    pre_len = 16'd0;
    @(negedge clk);
    arm = 1'b0;
    trig_hit = 1'b1;
    @(negedge clk);
    trig_hit = 1'b0;
    @(negedge clk);
    chk("post_state", state, 3);
    #1 rstn = 1'b0;
    #1 chk("async_reset", all_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    // arm ignored in WAIT, then abort beats trig_hit
    @(negedge clk);
    arm = 1'b1;
    pre_len = 16'd2;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_entry", {state, wt_addr}, {2'd2, 16'd2});
    arm = 1'b1;
    @(negedge clk);
    chk("arm_in_wait_addr", {state, wt_addr}, {2'd2, 16'd3});
    arm = 1'b0;
    abort = 1'b1;
    trig_hit = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {wt_ce, wt_en, state, triggered, done}, 0);
    abort = 1'b0;
    trig_hit = 1'b0;
    @(negedge clk);
    chk("abort_stays_idle", {wt_en, state}, 0);
`ifdef CW_CAPTURE_QUAL_EN
    begin
      int qv[6] = '{1, 0, 1, 0, 1, 1};
      int hv[6] = '{0, 0, 0, 1, 0, 1};
      int ev[6] = '{1, 0, 1, 0, 1, 1};
      int av[6] = '{0, 0, 1, 1, 2, 3};
      int tv[6] = '{0, 0, 0, 0, 0, 1};
      pre_len = 16'd2;
      for (int j = 0; j < 6; j++) begin
        arm = (j == 0);
        sample_qual = qv[j][0];
        trig_hit = hv[j][0];
        @(negedge clk);
        chk($sformatf("qual_s%0d", j + 1), {wt_ce, wt_en, wt_addr, triggered},
            {1'b1, ev[j][0], 16'(av[j]), tv[j][0]});
      end
      arm = 1'b0;
      trig_hit = 1'b0;
      sample_qual = 1'b1;
      chk("qual_trig_addr", trig_addr, 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
